hc283_nibble_sub: RTL and testbench



---
 rtl/hc283_pkg.sv | 19 +
 rtl/hc283_nibble_add.sv | 18 +
 rtl/hc283_nibble_sub.sv | 142 ++++++++++++++
 tb/tb_hc283_nibble_sub.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hc283_pkg.sv
// Shared definitions for the 74HC283-based nibble-serial datapath.
//   NIBBLE_W  : width of one '283 adder slice
//   state_t   : control FSM encoding for the nibble-serial subtractor
//   nib_count : number of nibble cycles needed for a given operand width
package hc283_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/hc283_nibble_add.sv
// RTL model of one 74HC283 slice: combinational 4-bit add with carry.
//   x, y : nibble operands
//   cin  : carry-in
//   s    : nibble sum
//   cout : carry-out
module hc283_nibble_add
  import hc283_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/hc283_nibble_sub.sv
// Nibble-serial subtractor/comparator. Computes a - b - bin over NIB cycles
// by adding the ones' complement of b through a single '283 slice, with the
// slice carry-in seeded to ~bin (carry = "no borrow").
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, borrow, ovf, zero)
//   dbg_state           : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and the
// result fields stay stable while out_valid=1 and out_ready=0.
module hc283_nibble_sub
  import hc283_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output state_t           dbg_state
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0]    a_sh, b_sh, diff_sh, diff_shift;
  logic [WIDTH-1:0]    diff_q;
  logic                carry;
  logic [CW-1:0]       count;
  logic                a_msb, b_msb;
  logic                borrow_q, ovf_q, zero_q;
  logic [NIBBLE_W-1:0] sum;
  logic                cout;
  logic                last;

  hc283_nibble_add u_add (
    .x    (a_sh[NIBBLE_W-1:0]),
    .y    (~b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  assign last = (count == CW'(NIB - 1));

  // Result nibbles enter at the top so that after NIB shifts the first
  // (least significant) nibble has landed in bits [3:0].
  assign diff_shift = (diff_sh >> NIBBLE_W) | (WIDTH'(sum) << (WIDTH - NIBBLE_W));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dbg_state = state_q;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. diff_q is loaded only on RUN->DONE so a partial result is
  // never visible on diff.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      diff_q   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            diff_sh <= '0;
            carry   <= ~bin;
            count   <= '0;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          diff_sh <= diff_shift;
          carry   <= cout;
          count   <= count + 1'b1;
          if (last) begin
            diff_q   <= diff_shift;
            borrow_q <= ~cout;
            zero_q   <= (diff_shift == '0);
            ovf_q    <= (a_msb != b_msb) && (diff_shift[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_hc283_nibble_sub.sv
module tb_hc283_nibble_sub;
  import hc283_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow, ovf, zero;
  state_t       dbg_state;

  hc283_nibble_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {diff, borrow, ovf, zero}
  logic [W+2:0] exp_q[$];

  // Reference model from the arithmetic definition of the result.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mbin);
    int          full;
    logic [W-1:0] d;
    logic         br, ov, z;
    full = int'(ma) - int'(mb) - int'(mbin);
    d    = full[W-1:0];
    br   = int'(ma) < (int'(mb) + int'(mbin));
    ov   = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    z    = (d == 0);
    return {d, br, ov, z};
  endfunction

  // Driver: offer one operation, wait (bounded) for out_valid.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    a = ia;
    b = ib;
    bin = ibin;
    exp_q.push_back(model(ia, ib, ibin));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, diff, borrow, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b diff=%h b=%b o=%b z=%b, want rdy=1 vld=0 diff=0000 flags=000",
               in_ready, out_valid, diff, borrow, ovf, zero);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[6]   = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h5555, 16'h0010};
    logic [W-1:0] vb[6]   = '{16'h0034, 16'h0001, 16'h0001, 16'hFFFF, 16'h5555, 16'h0000};
    logic         vbin[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W+2:0] fixed[6] = '{{16'h1200, 3'b000}, {16'hFFFF, 3'b100}, {16'h7FFF, 3'b010},
                               {16'h8000, 3'b110}, {16'h0000, 3'b001}, {16'h000F, 3'b000}};
    logic [W+2:0] e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vbin[i], lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if ({diff, borrow, ovf, zero} !== fixed[i] || e !== fixed[i]) begin
        errors++;
        $display("FAIL vec%0d_result: got diff=%h bof=%b%b%b want diff=%h bof=%b",
                 i, diff, borrow, ovf, zero, fixed[i][W+2:3], fixed[i][2:0]);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_release: got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+2:0] e;
    int lat;
    do_op(16'hA5C3, 16'h1F0E, 1'b1, lat);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {diff, borrow, ovf, zero} !== e) begin
        errors++;
        $display("FAIL stall%0d: got vld=%b rdy=%b diff=%h bof=%b%b%b want vld=1 rdy=0 diff=%h bof=%b",
                 i, out_valid, in_ready, diff, borrow, ovf, zero, e[W+2:3], e[2:0]);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL stall_release: got rdy=%b vld=%b st=%0d want rdy=1 vld=0 st=IDLE",
               in_ready, out_valid, dbg_state);
    end
    checks++;
    if ({diff, borrow, ovf, zero} !== e) begin
      errors++;
      $display("FAIL stall_hold_after: got diff=%h want %h", diff, e[W+2:3]);
    end
  endtask

  task automatic test_rst_mid_run();
    logic [W+2:0] e;
    int lat;
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    bin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, diff, borrow, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000} ||
        dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_run: got rdy=%b vld=%b diff=%h bof=%b%b%b st=%0d want idle, all zero",
               in_ready, out_valid, diff, borrow, ovf, zero, dbg_state);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_result: got vld=%b want 0", out_valid);
    end
    do_op(16'h0003, 16'h0001, 1'b0, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== LAT || {diff, borrow, ovf, zero} !== e || diff !== 16'h0002) begin
      errors++;
      $display("FAIL rst_fresh_op: got lat=%0d diff=%h want lat=%0d diff=0002", lat, diff, LAT);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [W+2:0] e;
    logic [W-1:0] ra, rb;
    logic         rbin;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      do_op(ra, rb, rbin, lat);
      e = exp_q.pop_front();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (lat !== LAT || out_valid !== 1'b1 || {diff, borrow, ovf, zero} !== e) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h bin=%b got lat=%0d diff=%h bof=%b%b%b want lat=%0d diff=%h bof=%b",
                 i, ra, rb, rbin, lat, diff, borrow, ovf, zero, LAT, e[W+2:3], e[2:0]);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_rst_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
